// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one WIDTH-bit two's-complement adder between NUM_REQ requesters.
//   A combinational round-robin scan picks at most one valid requester per
//   cycle. The winner's sum and ID are captured in a one-entry output buffer
//   that holds its result under backpressure until the consumer accepts it.
//
// Optional feature macro: ADDER_ARB_OVF_EN
//   When defined, adds the out_ovf port (registered signed-overflow flag).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]        per-requester request valid
//   req_ready  out  [NUM_REQ]        per-requester accept, one-hot or zero
//   req_in1    in   [NUM_REQ*WIDTH]  operand 1, requester i at [i*WIDTH +: WIDTH]
//   req_in2    in   [NUM_REQ*WIDTH]  operand 2, same packing
//   out_valid  out  result buffer holds a result
//   out_ready  in   consumer accepts the result
//   out_sum    out  [WIDTH]  in1 + in2 modulo 2^WIDTH
//   out_id     out  [ID_W]   requester that produced out_sum
//   out_ovf    out  signed overflow of out_sum (ADDER_ARB_OVF_EN only)
`timescale 1ns/1ps

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*WIDTH-1:0] req_in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [ID_W-1:0]          out_id
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                     out_ovf
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  sum_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic              ovf_q;

  logic              can_accept;
  logic              found;
  logic              fire;
  int                win_idx;
  logic [WIDTH-1:0]  sel_in1;
  logic [WIDTH-1:0]  sel_in2;
  logic [WIDTH-1:0]  sum_d;
  logic [ID_W-1:0]   id_d;
  logic [ID_W-1:0]   rr_ptr_d;
  logic              ovf_d;

  // Gating with rst_n keeps req_ready low for the whole reset, even though
  // the reset state itself (EMPTY) would otherwise allow an accept.
  assign can_accept = rst_n && ((state_q == EMPTY) || out_ready);

  // Round-robin scan from rr_ptr, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
        sel_in1 = req_in1[idx*WIDTH +: WIDTH];
        sel_in2 = req_in2[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign fire = can_accept && found;

  always_comb begin
    req_ready = '0;
    if (fire) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Datapath for the captured result; carry-out is simply dropped.
  assign sum_d    = sel_in1 + sel_in2;
  assign id_d     = ID_W'(win_idx);
  assign rr_ptr_d = ID_W'((win_idx + 1) % NUM_REQ);
  assign ovf_d    = (sel_in1[WIDTH-1] == sel_in2[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != sel_in1[WIDTH-1]);

  // Buffer FSM. A fire always (re)loads the buffer, which also covers the
  // drain-and-refill case when FULL with out_ready high. Without a fire a
  // FULL buffer empties only when the consumer takes it; stale sum/id remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      sum_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fire) begin
            state_q  <= FULL;
            sum_q    <= sum_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_d;
          end
        end
        FULL: begin
          if (fire) begin
            sum_q    <= sum_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_d;
          end else if (out_ready) begin
            state_q  <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_sum   = sum_q;
  assign out_id    = id_q;

`ifdef ADDER_ARB_OVF_EN
  assign out_ovf = ovf_q;
`else
  // Overflow flag is computed but has no consumer in this build.
  logic unusedOvf;
  assign unusedOvf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
`timescale 1ns/1ps

module tb_adder_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;
   localparam int ID_W    = 2;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       reqValid;
   logic [NUM_REQ-1:0]       reqReady;
   logic [NUM_REQ*WIDTH-1:0] reqIn1;
   logic [NUM_REQ*WIDTH-1:0] reqIn2;
   logic                     outValid;
   logic                     outReady;
   logic [WIDTH-1:0]         outSum;
   logic [ID_W-1:0]          outId;
`ifdef ADDER_ARB_OVF_EN
   logic                     outOvf;
`endif

   int assertCount;
   int failCount;

   adder_arbiter #(
      .NUM_REQ(NUM_REQ),
      .WIDTH(WIDTH),
      .ID_W(ID_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(reqValid),
      .req_ready(reqReady),
      .req_in1(reqIn1),
      .req_in2(reqIn2),
      .out_valid(outValid),
      .out_ready(outReady),
      .out_sum(outSum),
      .out_id(outId)
`ifdef ADDER_ARB_OVF_EN
      ,
      .out_ovf(outOvf)
`endif
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one operand pair on one requester.
   task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      reqIn1[idx*WIDTH +: WIDTH] = a;
      reqIn2[idx*WIDTH +: WIDTH] = b;
   endtask

   // Single request from requester idx into a buffer that can accept:
   // grant must be visible before the edge, result one cycle later.
   task automatic singleRequest(input string tag, input int idx, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expSum,
                                input logic expOvf);
      logic [NUM_REQ-1:0] onehot;
      onehot = '0;
      onehot[idx] = 1'b1;
      applyStimulus(idx, a, b);
      reqValid = onehot;
      outReady = 1'b1;
      #1;
      checkOutput({tag, ".ready"}, 64'(reqReady), 64'(onehot));
      @(posedge clk);
      #1;
      reqValid = '0;
      @(negedge clk);
      checkOutput({tag, ".valid"}, 64'(outValid), 64'd1);
      checkOutput({tag, ".sum"}, 64'(outSum), 64'(expSum));
      checkOutput({tag, ".id"}, 64'(outId), 64'(idx));
`ifdef ADDER_ARB_OVF_EN
      checkOutput({tag, ".ovf"}, 64'(outOvf), 64'(expOvf));
`else
      if (expOvf === 1'bx) $display("[TB] unexpected X overflow expectation");
`endif
   endtask

   // Clean synchronous-looking reset pulse; ends just after a rising edge.
   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst_n    = 1'b0;
      reqValid = '1;
      reqIn1   = '0;
      reqIn2   = '0;
      outReady = 1'b1;

      // Reset state, with all requests pending to show ready stays low.
      #3;
      checkOutput("reset.valid", 64'(outValid), 64'd0);
      checkOutput("reset.sum", 64'(outSum), 64'd0);
      checkOutput("reset.id", 64'(outId), 64'd0);
      checkOutput("reset.ready", 64'(reqReady), 64'd0);
`ifdef ADDER_ARB_OVF_EN
      checkOutput("reset.ovf", 64'(outOvf), 64'd0);
`endif
      reqValid = '0;
      resetDut();

      // Basic arithmetic through different requesters.
      singleRequest("add1p2", 0, 32'd1, 32'd2, 32'd3, 1'b0);
      singleRequest("neg10p5", 2, 32'hFFFFFFF6, 32'd5, 32'hFFFFFFFB, 1'b0);
      singleRequest("big", 2, 32'd10500000, 32'd0, 32'd10500000, 1'b0);
      singleRequest("wrap", 2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);

      // Rotation from reset with all requesters active.
      @(posedge clk);
      #1;
      resetDut();
      for (int i = 0; i < NUM_REQ; i++) begin
         applyStimulus(i, WIDTH'(i * 16), WIDTH'(100 + i));
      end
      reqValid = '1;
      outReady = 1'b1;
      for (int k = 0; k < 8; k++) begin
         logic [NUM_REQ-1:0] expReady;
         expReady = '0;
         expReady[k % NUM_REQ] = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("rot%0d.ready", k), 64'(reqReady), 64'(expReady));
         if (k > 0) begin
            checkOutput($sformatf("rot%0d.id", k), 64'(outId), 64'((k - 1) % NUM_REQ));
            checkOutput($sformatf("rot%0d.sum", k), 64'(outSum), 64'(17 * ((k - 1) % NUM_REQ) + 100));
         end
      end
      @(posedge clk);
      #1;
      reqValid = '0;
      @(negedge clk);
      checkOutput("rot.last.id", 64'(outId), 64'd3);
      checkOutput("rot.last.sum", 64'(outSum), 64'd151);

      // Backpressure: buffer drains on this edge, then fill with req 1.
      @(posedge clk);
      #1;
      outReady = 1'b0;
      applyStimulus(1, 32'd7, 32'd8);
      reqValid = 4'b0010;
      #1;
      checkOutput("bp.emptyReady", 64'(reqReady), 64'b0010);
      @(posedge clk);
      #1;
      applyStimulus(3, 32'd20, 32'd22);
      reqValid = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("bp%0d.valid", k), 64'(outValid), 64'd1);
         checkOutput($sformatf("bp%0d.sum", k), 64'(outSum), 64'd15);
         checkOutput($sformatf("bp%0d.id", k), 64'(outId), 64'd1);
         checkOutput($sformatf("bp%0d.ready", k), 64'(reqReady), 64'd0);
      end
      outReady = 1'b1;
      #1;
      checkOutput("bp.drainReady", 64'(reqReady), 64'b1000);
      @(posedge clk);
      #1;
      applyStimulus(1, 32'd1, 32'd1);
      reqValid = 4'b0010;
      @(negedge clk);
      checkOutput("bp.next.valid", 64'(outValid), 64'd1);
      checkOutput("bp.next.sum", 64'(outSum), 64'd42);
      checkOutput("bp.next.id", 64'(outId), 64'd3);
      checkOutput("bp.next.ready", 64'(reqReady), 64'b0010);

      // Asynchronous reset while FULL; pointer is 2 before the reset.
      @(posedge clk);
      #1;
      outReady = 1'b0;
      applyStimulus(0, 32'h11, 32'h22);
      reqValid = '1;
      @(negedge clk);
      checkOutput("ar.pre.id", 64'(outId), 64'd1);
      checkOutput("ar.pre.sum", 64'(outSum), 64'd2);
      checkOutput("ar.pre.ready", 64'(reqReady), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar.valid", 64'(outValid), 64'd0);
      checkOutput("ar.ready", 64'(reqReady), 64'd0);
      checkOutput("ar.sum", 64'(outSum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      outReady = 1'b1;
      #1;
      checkOutput("ar.firstReady", 64'(reqReady), 64'b0001);
      @(posedge clk);
      #1;
      reqValid = '0;
      @(negedge clk);
      checkOutput("ar.first.id", 64'(outId), 64'd0);
      checkOutput("ar.first.sum", 64'(outSum), 64'h33);

`ifdef ADDER_ARB_OVF_EN
      singleRequest("ovfPos", 1, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
      singleRequest("ovfNeg", 2, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1);
`endif

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit two's-complement adder between NUM_REQ requesters (e.g. PC+4 incrementer, branch-target calculation, address generation). Each requester presents an operand pair under a valid/ready handshake. The arbiter grants at most one request per cycle and registers the sum together with the winner's ID. The result is held in a one-entry output buffer with backpressure until the consumer accepts it.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width in bits
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ))

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_in1  input  NUM_REQ*WIDTH  operand 1, requester i at bits [i*WIDTH +: WIDTH]
- req_in2  input  NUM_REQ*WIDTH  operand 2, same packing
- out_valid  output  1  registered result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  registered in1+in2, modulo 2^WIDTH
- out_id  output  ID_W  index of the requester that produced out_sum
- out_ovf  output  1  signed overflow of out_sum; present only with ADDER_ARB_OVF_EN

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = EMPTY, or (FULL and out_ready). A full buffer that is being drained accepts a new request in the same cycle.
- Arbitration is combinational:
  - Scan starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i] = can_accept and (i is the winner). All other bits are 0.
- Handshake: a request fires on cycle t when req_valid[i] and req_ready[i] are both high.
  - At the edge ending t: out_sum <= in1_i + in2_i, out_id <= i, state <= FULL, rr_ptr <= (i+1) mod NUM_REQ.
- Drain without a new fire (FULL, out_ready=1, no winner): state <= EMPTY. out_sum and out_id hold their stale values.
- FULL and out_ready=0: all outputs hold and req_ready = 0.
- rr_ptr changes only on a fire.
- Arithmetic: unsigned wrap, carry-out discarded. Example: 0xFFFFFFFF + 1 = 0.
- Requesters must hold valid and operands stable until ready. The arbiter does not require this for correctness; it samples operands only on the fire cycle.

## Timing
- Reset (rst_n=0, asynchronous, any cycle): out_valid=0, out_sum=0, out_id=0, out_ovf=0, rr_ptr=0, state=EMPTY.
  - req_ready=0 while rst_n=0.
  - A request in flight is discarded.
- First arbitration happens on the first rising edge after rst_n deasserts.
- Latency: fire on cycle t gives out_valid=1 with the result on cycle t+1.
- Throughput: one result per cycle while out_ready=1.
- req_ready depends combinationally on req_valid, out_ready and state. req_valid must not depend on req_ready.
- Simultaneous requests on all inputs: grants rotate 0,1,2,3,0,… starting from reset.
- A single persistent requester is granted every cycle.

## Configuration
- Macro ADDER_ARB_OVF_EN.
- Defined:
  - out_ovf port exists.
  - It is registered with out_sum.
  - out_ovf = (in1[MSB] == in2[MSB]) and (sum[MSB] != in1[MSB]).
  - Reset value is 0.
- Undefined: the out_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then requester 0 sends in1=1, in2=2 with out_ready=1. Required: next cycle out_valid=1, out_sum=3, out_id=0.
- Requester 2 sends -10 + 5. Required: out_sum=0xFFFFFFFB, out_id=2. Then 10500000 + 0 gives 10500000. Then 0xFFFFFFFF + 1 gives 0; with ADDER_ARB_OVF_EN, out_ovf=0.
- All four req_valid high for 8 cycles with out_ready=1. Required: out_id sequence 0,1,2,3,0,1,2,3 and req_ready one-hot every cycle.
- Hold out_ready=0 for 3 cycles after one result. Required: out_valid and out_sum stable, req_ready=0, pending requests not consumed. Raising out_ready drains the buffer and fires the next grant in the same cycle.
- Assert rst_n=0 mid-stream, between edges, while FULL. Required: out_valid=0 and req_ready=0 immediately; after release, the first grant goes to requester 0.
- With ADDER_ARB_OVF_EN: 0x7FFFFFFF + 1. Required: out_sum=0x80000000, out_ovf=1. Then 0x80000000 + 0xFFFFFFFF gives out_sum=0x7FFFFFFF, out_ovf=1.
